fft_mag_sq: RTL and testbench

- Upstream feeder of the square-root stage in the FFT magnitude path.
- Accepts one complex FFT bin (real, imaginary; IEEE-754 single) per handshake and computes re²+im² in simplified single precision.
- Presents the result on argument, pulses start, then holds argument stable until the square-root stage reports done.
- Self-contained: a sequential squarer reused for both operands plus a positive-only adder; no external FP cores.

---
 rtl/fft_mag_sq.sv | 198 +++++++++++++++++++
 tb/tb_fft_mag_sq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_sq.sv
// Squares the real and imaginary parts of one FFT bin and adds them, using simplified single precision.
// The result is handed to the square-root stage with a start pulse and then held until that stage finishes.
module fft_mag_sq #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        in_valid,
    input  logic [31:0] in_re,
    input  logic [31:0] in_im,
    output logic        in_ready,
    output logic [31:0] argument,
    output logic        start,
    input  logic        sqrt_done,
    output logic        busy,
    output logic        overflow,
    output logic        ack_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [30:0] SAT = 31'h7F7FFFFF;

    typedef enum logic [2:0] {
        IDLE,
        SQ_RE,
        SQ_IM,
        SUM,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t      state_q;
    logic [30:0] re_q;
    logic [30:0] im_q;
    logic        primed_q;
    logic [24:0] prod_q;
    logic [30:0] sqA_q;
    logic [30:0] sqB_q;
    logic [31:0] argument_q;
    logic        start_q;
    logic        overflow_q;
    logic        ackErr_q;
    logic [TW-1:0] timer_q;

    logic [22:0] mulMan;
    logic [47:0] mulExt;
    logic [24:0] prod_d;
    logic [7:0]  sqExp;
    logic [9:0]  twoE;
    logic [22:0] sqMan;
    logic [30:0] sqRes_d;
    logic        sqOvf_d;

    logic        aBig;
    logic [7:0]  expBig;
    logic [7:0]  expSmall;
    logic [23:0] manBig;
    logic [23:0] manSmall;
    logic [7:0]  expDiff;
    logic [23:0] aligned;
    logic [24:0] manSum;
    logic [30:0] sum_d;
    logic        addOvf_d;

    // The multiplier result is registered, so SQ_RE spends one extra cycle priming it with the real mantissa.
    always_comb begin
        mulMan = (state_q == SQ_RE && !primed_q) ? re_q[22:0] : im_q[22:0];
        mulExt = {24'd0, 1'b1, mulMan};
        prod_d = 25'((mulExt * mulExt) >> 23);
    end

    always_comb begin
        sqExp   = (state_q == SQ_IM) ? im_q[30:23] : re_q[30:23];
        twoE    = {1'b0, sqExp, 1'b0} + {9'd0, prod_q[24]};
        sqMan   = prod_q[24] ? prod_q[23:1] : prod_q[22:0];
        sqRes_d = '0;
        sqOvf_d = 1'b0;
        if (sqExp == 8'hFF) begin
            sqRes_d = SAT;
            sqOvf_d = 1'b1;
        end else if (sqExp != 8'd0) begin
            if (twoE >= 10'd382) begin
                sqRes_d = SAT;
                sqOvf_d = 1'b1;
            end else if (twoE > 10'd127) begin
                sqRes_d = {twoE[7:0] - 8'd127, sqMan};
            end
        end
    end

    // Both operands are non-negative squares, so the sum never cancels and only a right shift can be needed.
    always_comb begin
        aBig     = sqA_q[30:23] >= sqB_q[30:23];
        expBig   = aBig ? sqA_q[30:23] : sqB_q[30:23];
        expSmall = aBig ? sqB_q[30:23] : sqA_q[30:23];
        manBig   = aBig ? {1'b1, sqA_q[22:0]} : {1'b1, sqB_q[22:0]};
        manSmall = aBig ? {1'b1, sqB_q[22:0]} : {1'b1, sqA_q[22:0]};
        expDiff  = expBig - expSmall;
        aligned  = (expDiff >= 8'd24) ? 24'd0 : (manSmall >> expDiff);
        manSum   = {1'b0, manBig} + {1'b0, aligned};
        sum_d    = '0;
        addOvf_d = 1'b0;
        if (sqA_q[30:23] == 8'd0) begin
            sum_d = sqB_q;
        end else if (sqB_q[30:23] == 8'd0) begin
            sum_d = sqA_q;
        end else if (manSum[24]) begin
            if (expBig == 8'd254) begin
                sum_d    = SAT;
                addOvf_d = 1'b1;
            end else begin
                sum_d = {expBig + 8'd1, manSum[23:1]};
            end
        end else begin
            sum_d = {expBig, manSum[22:0]};
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            re_q       <= '0;
            im_q       <= '0;
            primed_q   <= 1'b0;
            prod_q     <= '0;
            sqA_q      <= '0;
            sqB_q      <= '0;
            argument_q <= '0;
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
            ackErr_q   <= 1'b0;
            timer_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        re_q     <= in_re[30:0];
                        im_q     <= in_im[30:0];
                        primed_q <= 1'b0;
                        state_q  <= SQ_RE;
                    end
                end
                SQ_RE: begin
                    prod_q <= prod_d;
                    if (!primed_q) begin
                        primed_q <= 1'b1;
                    end else begin
                        sqA_q      <= sqRes_d;
                        overflow_q <= overflow_q | sqOvf_d;
                        state_q    <= SQ_IM;
                    end
                end
                SQ_IM: begin
                    sqB_q      <= sqRes_d;
                    overflow_q <= overflow_q | sqOvf_d;
                    state_q    <= SUM;
                end
                SUM: begin
                    argument_q <= {1'b0, sum_d};
                    overflow_q <= overflow_q | addOvf_d;
                    start_q    <= 1'b1;
                    state_q    <= ISSUE;
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    timer_q <= '0;
                    state_q <= WAIT_BUSY;
                end
                // The root stage still shows done for a cycle after start; wait for it to drop, but not forever.
                WAIT_BUSY: begin
                    if (!sqrt_done) begin
                        state_q <= WAIT_DONE;
                    end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                        ackErr_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (sqrt_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign argument = argument_q;
    assign start    = start_q;
    assign overflow = overflow_q;
    assign ack_err  = ackErr_q;

endmodule

// File: tb/tb_fft_mag_sq.sv
// Directed bench for fft_mag_sq: hand-computed magnitudes, handshake timing, timeout and reset behaviour.
module tb_fft_mag_sq;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        in_valid;
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic        in_ready;
    logic [31:0] argument;
    logic        start;
    logic        sqrt_done;
    logic        busy;
    logic        overflow;
    logic        ack_err;

    int checks = 0;
    int errors = 0;
    int startPulses = 0;

    fft_mag_sq #(.ACK_TIMEOUT(15)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_ready  (in_ready),
        .argument  (argument),
        .start     (start),
        .sqrt_done (sqrt_done),
        .busy      (busy),
        .overflow  (overflow),
        .ack_err   (ack_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start === 1'b1) startPulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present a bin and hold it until the design accepts it; returns just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] re, input logic [31:0] im);
        int waitCycles = 0;
        in_re    = re;
        in_im    = im;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Returns one cycle after the start edge, with the design in WAIT_BUSY.
    task automatic runTxn(input string tag, input logic [31:0] re, input logic [31:0] im, input logic [31:0] expArg);
        int lat = 0;
        applyStimulus(re, im);
        while (start !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_argument"}, argument, expArg);
        tick();
        checkOutput({tag, "_start_width"}, {31'd0, start}, 32'd0);
    endtask

    task automatic finishTxn(input string tag);
        sqrt_done = 1'b0;
        tick();
        tick();
        checkOutput({tag, "_busy_wait_done"}, {31'd0, busy}, 32'd1);
        sqrt_done = 1'b1;
        tick();
        checkOutput({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int pulsesBefore;
        int busyBad;
        int readyBad;
        int argBad;

        n_reset   = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        sqrt_done = 1'b1;
        #12;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_start", {31'd0, start}, 32'd0);
        checkOutput("reset_argument", argument, 32'd0);
        checkOutput("reset_flags", {30'd0, overflow, ack_err}, 32'd0);
        tick();
        n_reset = 1'b1;
        tick();

        $display("[TB] 3.0 / 4.0 bin");
        runTxn("t34", 32'h40400000, 32'h40800000, 32'h41C80000);
        repeat (4) tick();
        checkOutput("t34_wait_busy", {30'd0, busy, in_ready}, 32'd2);
        finishTxn("t34");
        checkOutput("t34_ack_err", {31'd0, ack_err}, 32'd0);

        $display("[TB] -1.0 / 0 bin");
        runTxn("neg1", 32'hBF800000, 32'h00000000, 32'h3F800000);
        finishTxn("neg1");
        checkOutput("neg1_overflow", {31'd0, overflow}, 32'd0);

        $display("[TB] 1.0 / 1.0 carry");
        runTxn("carry", 32'h3F800000, 32'h3F800000, 32'h40000000);
        finishTxn("carry");

        $display("[TB] underflow and alignment drop");
        runTxn("uflow", 32'h1F800000, 32'h00000000, 32'h00000000);
        finishTxn("uflow");
        runTxn("align", 32'h3F800000, 32'h39000000, 32'h3F800000);
        finishTxn("align");
        checkOutput("align_overflow", {31'd0, overflow}, 32'd0);

        $display("[TB] saturation");
        runTxn("sat", 32'h7F000000, 32'h3F800000, 32'h7F7FFFFF);
        finishTxn("sat");
        checkOutput("sat_overflow", {31'd0, overflow}, 32'd1);
        runTxn("sticky", 32'h40400000, 32'h40800000, 32'h41C80000);
        finishTxn("sticky");
        checkOutput("sticky_overflow", {31'd0, overflow}, 32'd1);

        $display("[TB] ack timeout");
        runTxn("tmo", 32'h40400000, 32'h40800000, 32'h41C80000);
        repeat (14) tick();
        checkOutput("tmo_before_expiry", {30'd0, busy, ack_err}, 32'd2);
        tick();
        checkOutput("tmo_ack_err", {31'd0, ack_err}, 32'd1);
        checkOutput("tmo_in_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] long root computation");
        runTxn("long", 32'h3F800000, 32'h3F800000, 32'h40000000);
        tick();
        sqrt_done = 1'b0;
        in_re     = 32'h40400000;
        in_im     = 32'h40800000;
        in_valid  = 1'b1;
        pulsesBefore = startPulses;
        busyBad  = 0;
        readyBad = 0;
        argBad   = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy !== 1'b1) busyBad++;
            if (in_ready !== 1'b0) readyBad++;
            if (argument !== 32'h40000000) argBad++;
        end
        checkOutput("long_busy_drops", 32'(busyBad), 32'd0);
        checkOutput("long_ready_rises", 32'(readyBad), 32'd0);
        checkOutput("long_arg_changes", 32'(argBad), 32'd0);
        checkOutput("long_extra_starts", 32'(startPulses - pulsesBefore), 32'd0);
        in_valid  = 1'b0;
        sqrt_done = 1'b1;
        tick();
        checkOutput("long_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("long_arg_held", argument, 32'h40000000);

        $display("[TB] reset during WAIT_DONE");
        runTxn("rstwd", 32'h40400000, 32'h40800000, 32'h41C80000);
        sqrt_done = 1'b0;
        tick();
        tick();
        #2;
        n_reset = 1'b0;
        #1;
        checkOutput("rstwd_argument", argument, 32'd0);
        checkOutput("rstwd_ctrl", {28'd0, in_ready, busy, start, 1'b0}, 32'h8);
        checkOutput("rstwd_flags", {30'd0, overflow, ack_err}, 32'd0);
        sqrt_done = 1'b1;
        tick();
        n_reset = 1'b1;
        tick();

        $display("[TB] reset during SQ_IM");
        applyStimulus(32'h40400000, 32'h40800000);
        tick();
        tick();
        checkOutput("rstim_busy_before", {31'd0, busy}, 32'd1);
        #2;
        n_reset = 1'b0;
        #1;
        checkOutput("rstim_ctrl", {29'd0, in_ready, busy, start}, 32'h4);
        checkOutput("rstim_argument", argument, 32'd0);
        tick();
        tick();
        n_reset = 1'b1;
        pulsesBefore = startPulses;
        repeat (10) tick();
        checkOutput("rstim_no_start", 32'(startPulses - pulsesBefore), 32'd0);
        checkOutput("rstim_idle", {30'd0, in_ready, busy}, 32'd2);

        runTxn("after", 32'h40400000, 32'h40800000, 32'h41C80000);
        finishTxn("after");
        checkOutput("after_flags", {30'd0, overflow, ack_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
